// File: rtl/uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// uart_tx_arbiter
//
// Purpose:
//   Shares one 8N1 UART transmitter (start/busy interface) among N_REQ byte
//   sources. Grants are round-robin at packet granularity. A grant is held
//   until the byte flagged req_last has been sent, or until the granted source
//   has shown no valid byte for IDLE_TIMEOUT cycles. A transmitter that never
//   raises tx_busy after tx_start is reported through the sticky err_ack flag,
//   and the byte is then treated as sent.
//
// Handshake:
//   A byte moves from source i to the arbiter on a rising clk edge where
//   req_valid[i] and req_ready[i] are both high. req_ready is combinational.
//   It is high only for the granted source, only in SEND, and only while
//   tx_busy is low. A source may change valid/data freely while it is not
//   ready.
//
// Ports:
//   clk, rst_n    system clock, asynchronous active-low reset
//   req_valid     per-source byte valid                    [N_REQ]
//   req_data      per-source byte, source i at [8*i+7:8*i]  [8*N_REQ]
//   req_last      per-source "last byte of packet"          [N_REQ]
//   req_ready     per-source accept, at most one bit set    [N_REQ]
//   tx_data       byte to the transmitter, held until the next accept
//   tx_start      one-cycle start pulse to the transmitter
//   tx_busy       transmitter busy (start bit .. stop bit)
//   grant_active  a source currently owns the transmitter
//   grant_id      owning source index (meaningful while grant_active)
//   err_ack       sticky: tx_busy did not rise within ACK_TIMEOUT cycles
//   dbg_state     current FSM state (0 IDLE, 1 SEND, 2 WAIT_ACK, 3 WAIT_DONE)
// ---------------------------------------------------------------------------
module uart_tx_arbiter #(
  parameter int N_REQ        = 4,
  parameter int IDW          = 2,
  parameter int IDLE_TIMEOUT = 4096,
  parameter int ACK_TIMEOUT  = 15
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [8*N_REQ-1:0] req_data,
  input  logic [N_REQ-1:0]   req_last,
  output logic [N_REQ-1:0]   req_ready,
  output logic [7:0]         tx_data,
  output logic               tx_start,
  input  logic               tx_busy,
  output logic               grant_active,
  output logic [IDW-1:0]     grant_id,
  output logic               err_ack,
  output logic [1:0]         dbg_state
);

  localparam int IDLE_W = $clog2(IDLE_TIMEOUT + 1);
  localparam int ACK_W  = $clog2(ACK_TIMEOUT + 1);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_SEND      = 2'd1,
    ST_WAIT_ACK  = 2'd2,
    ST_WAIT_DONE = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [IDW-1:0]    ptr_q, ptr_d;
  logic [IDW-1:0]    grant_id_q, grant_id_d;
  logic              grant_active_q, grant_active_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic              tx_start_q, tx_start_d;
  logic              last_q, last_d;
  logic              err_ack_q, err_ack_d;
  logic [IDLE_W-1:0] idle_cnt_q, idle_cnt_d;
  logic [ACK_W-1:0]  ack_cnt_q, ack_cnt_d;

  // Round-robin pick: first valid source scanning ptr+1, ptr+2, ... mod N_REQ.
  // ptr holds the last released owner, so that owner comes last next round.
  logic           any_valid;
  logic [IDW-1:0] pick;
  logic [IDW-1:0] scan_idx;

  always_comb begin
    any_valid = 1'b0;
    pick      = '0;
    scan_idx  = '0;
    for (int k = 0; k < N_REQ; k++) begin
      scan_idx = IDW'((int'(ptr_q) + 1 + k) % N_REQ);
      if (!any_valid && req_valid[scan_idx]) begin
        any_valid = 1'b1;
        pick      = scan_idx;
      end
    end
  end

  // Granted source's request lines.
  logic       g_valid;
  logic [7:0] g_data;
  logic       g_last;

  always_comb begin
    g_valid = req_valid[grant_id_q];
    g_data  = req_data[8*grant_id_q +: 8];
    g_last  = req_last[grant_id_q];
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      ptr_q          <= IDW'(N_REQ - 1);
      grant_id_q     <= '0;
      grant_active_q <= 1'b0;
      tx_data_q      <= '0;
      tx_start_q     <= 1'b0;
      last_q         <= 1'b0;
      err_ack_q      <= 1'b0;
      idle_cnt_q     <= '0;
      ack_cnt_q      <= '0;
    end else begin
      state_q        <= state_d;
      ptr_q          <= ptr_d;
      grant_id_q     <= grant_id_d;
      grant_active_q <= grant_active_d;
      tx_data_q      <= tx_data_d;
      tx_start_q     <= tx_start_d;
      last_q         <= last_d;
      err_ack_q      <= err_ack_d;
      idle_cnt_q     <= idle_cnt_d;
      ack_cnt_q      <= ack_cnt_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d        = state_q;
    ptr_d          = ptr_q;
    grant_id_d     = grant_id_q;
    grant_active_d = grant_active_q;
    tx_data_d      = tx_data_q;
    tx_start_d     = 1'b0;
    last_d         = last_q;
    err_ack_d      = err_ack_q;
    idle_cnt_d     = idle_cnt_q;
    ack_cnt_d      = ack_cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (any_valid) begin
          grant_id_d     = pick;
          grant_active_d = 1'b1;
          idle_cnt_d     = '0;
          state_d        = ST_SEND;
        end
      end

      ST_SEND: begin
        if (g_valid && !tx_busy) begin
          tx_data_d  = g_data;
          last_d     = g_last;
          tx_start_d = 1'b1;
          idle_cnt_d = '0;
          ack_cnt_d  = '0;
          state_d    = ST_WAIT_ACK;
        end else if (g_valid) begin
          idle_cnt_d = '0;
        end else if (idle_cnt_q == IDLE_W'(IDLE_TIMEOUT - 1)) begin
          // Owner stalled too long mid-packet: drop the grant.
          ptr_d          = grant_id_q;
          grant_active_d = 1'b0;
          idle_cnt_d     = '0;
          state_d        = ST_IDLE;
        end else begin
          idle_cnt_d = idle_cnt_q + IDLE_W'(1);
        end
      end

      ST_WAIT_ACK: begin
        if (tx_busy) begin
          state_d = ST_WAIT_DONE;
        end else if (ack_cnt_q == ACK_W'(ACK_TIMEOUT - 1)) begin
          // Transmitter never acknowledged; flag it and carry on as if the
          // byte had gone out, so one dead transmitter cannot wedge sources.
          err_ack_d = 1'b1;
          ack_cnt_d = '0;
          if (last_q) begin
            ptr_d          = grant_id_q;
            grant_active_d = 1'b0;
            state_d        = ST_IDLE;
          end else begin
            state_d = ST_SEND;
          end
        end else begin
          ack_cnt_d = ack_cnt_q + ACK_W'(1);
        end
      end

      ST_WAIT_DONE: begin
        if (!tx_busy) begin
          if (last_q) begin
            ptr_d          = grant_id_q;
            grant_active_d = 1'b0;
            state_d        = ST_IDLE;
          end else begin
            state_d = ST_SEND;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs.
  always_comb begin
    req_ready = '0;
    if (state_q == ST_SEND && !tx_busy) begin
      req_ready[grant_id_q] = 1'b1;
    end
    tx_data      = tx_data_q;
    tx_start     = tx_start_q;
    grant_active = grant_active_q;
    grant_id     = grant_id_q;
    err_ack      = err_ack_q;
    dbg_state    = state_q;
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_arbiter
//
// Drives uart_tx_arbiter with four byte-queue producers and a simple
// transmitter model (tx_busy high for BUSY_CYC cycles after each tx_start).
// Expected transmit order is listed per scenario in exp_q as {id, byte}.
// ---------------------------------------------------------------------------
module tb_uart_tx_arbiter;

  localparam int N        = 4;
  localparam int BUSY_CYC = 20;

  // Clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // DUT signals
  logic [N-1:0]   req_valid = '0;
  logic [8*N-1:0] req_data  = '0;
  logic [N-1:0]   req_last  = '0;
  logic [N-1:0]   req_ready;
  logic [7:0]     tx_data;
  logic           tx_start;
  logic           tx_busy = 1'b0;
  logic           grant_active;
  logic [1:0]     grant_id;
  logic           err_ack;
  logic [1:0]     dbg_state;

  uart_tx_arbiter #(
    .N_REQ(4), .IDW(2), .IDLE_TIMEOUT(64), .ACK_TIMEOUT(15)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
    .req_ready(req_ready),
    .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy),
    .grant_active(grant_active), .grant_id(grant_id),
    .err_ack(err_ack), .dbg_state(dbg_state)
  );

  // Scoreboard
  logic [10:0] exp_q[$];
  int n_assert = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [10:0] entry(input int id, input logic [7:0] d);
    return {3'(id), d};
  endfunction

  // Producers: per-source byte FIFOs {last, data}
  logic [8:0] src_mem[N][64];
  int src_wr[N];
  int src_rd[N];
  logic [N-1:0] pend = '0;
  int  busy_cnt = 0;
  logic [7:0] cap_data = '0;
  logic tie_busy_low = 1'b0;

  task automatic push_byte(input int s, input logic [7:0] d, input logic l);
    src_mem[s][src_wr[s] % 64] = {l, d};
    src_wr[s]++;
  endtask

  function automatic bit queues_empty();
    for (int i = 0; i < N; i++) if (src_rd[i] != src_wr[i]) return 0;
    return 1;
  endfunction

  // Engine: monitor, transmitter model and producers, all on the falling edge.
  initial begin : engine
    for (int i = 0; i < N; i++) begin src_wr[i] = 0; src_rd[i] = 0; end
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        tx_busy = 1'b0; busy_cnt = 0; pend = '0;
        req_valid = '0; req_last = '0; req_data = '0;
        for (int i = 0; i < N; i++) src_rd[i] = src_wr[i];
      end else begin
        // Monitor: every tx_start must match the next expected byte.
        if (tx_start) begin
          if (exp_q.size() == 0) begin
            n_assert++; n_fail++;
            $display("FAIL unexpected_tx_start: got id %0d byte 0x%0h, expected none", grant_id, tx_data);
          end else begin
            check("tx_start_byte", 32'({1'b0, grant_id, tx_data}), 32'(exp_q.pop_front()));
          end
        end
        // Transmitter model
        if (busy_cnt > 0) begin
          busy_cnt--;
          if (busy_cnt == 0) begin
            tx_busy = 1'b0;
            check("tx_data_hold", 32'(tx_data), 32'(cap_data));
          end
        end else if (tx_start && !tie_busy_low) begin
          busy_cnt = BUSY_CYC;
          tx_busy  = 1'b1;
          cap_data = tx_data;
        end
        // Producers: retire bytes accepted on the last rising edge, present heads.
        for (int i = 0; i < N; i++) if (pend[i]) src_rd[i]++;
        for (int i = 0; i < N; i++) begin
          if (src_rd[i] != src_wr[i]) begin
            req_valid[i]       = 1'b1;
            req_data[8*i +: 8] = src_mem[i][src_rd[i] % 64][7:0];
            req_last[i]        = src_mem[i][src_rd[i] % 64][8];
          end else begin
            req_valid[i]       = 1'b0;
            req_data[8*i +: 8] = 8'h00;
            req_last[i]        = 1'b0;
          end
        end
        #1;
        pend = req_valid & req_ready;
        if (req_ready != '0) check("ready_onehot", 32'($countones(req_ready)), 32'd1);
        if (pend != '0 && exp_q.size() != 0) begin
          int who = 0;
          for (int i = 0; i < N; i++) if (pend[i]) who = i;
          check("ready_owner", 32'(who), 32'(exp_q[0][10:8]));
        end
      end
    end
  end

  // Driver helpers
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    tie_busy_low = 1'b0;
    exp_q.delete();
    for (int i = 0; i < N; i++) src_rd[i] = src_wr[i];
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_state(input logic [1:0] st, input int budget, input string name);
    int n = 0;
    do begin @(posedge clk); #1; n++; end while (dbg_state != st && n < budget);
    check(name, 32'(dbg_state), 32'(st));
  endtask

  task automatic wait_start(input int budget);
    int n = 0;
    do begin @(posedge clk); #1; n++; end while (!tx_start && n < budget);
    check("wait_tx_start", 32'(tx_start), 32'd1);
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    bit done = 0;
    while (!done && n < budget) begin
      @(posedge clk); #1; n++;
      done = queues_empty() && dbg_state == 2'd0 && busy_cnt == 0;
    end
    check("wait_idle", 32'(done), 32'd1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_req_ready"},    32'(req_ready),    32'd0);
    check({tag, "_tx_data"},      32'(tx_data),      32'd0);
    check({tag, "_tx_start"},     32'(tx_start),     32'd0);
    check({tag, "_grant_active"}, 32'(grant_active), 32'd0);
    check({tag, "_grant_id"},     32'(grant_id),     32'd0);
    check({tag, "_err_ack"},      32'(err_ack),      32'd0);
    check({tag, "_state"},        32'(dbg_state),    32'd0);
  endtask

  // Contention vectors, each started from reset (pointer at 3, source 0 first).
  // exp_ids: nibble j holds the source expected in the j-th transmitted byte.
  typedef struct {
    logic [3:0]  mask;
    int          pkts;
    int          n_exp;
    logic [31:0] exp_ids;
  } vec_t;

  vec_t vecs[6];

  initial begin : main
    int n;
    int cnt[N];
    logic [7:0] d;
    logic [3:0] id;

    vecs[0] = '{4'b0001, 1, 1, 32'h0000_0000};
    vecs[1] = '{4'b1111, 1, 4, 32'h0000_3210};
    vecs[2] = '{4'b1010, 1, 2, 32'h0000_0031};
    vecs[3] = '{4'b0101, 2, 4, 32'h0000_2020};
    vecs[4] = '{4'b1111, 2, 8, 32'h3210_3210};
    vecs[5] = '{4'b1100, 1, 2, 32'h0000_0032};

    // Reset values
    @(posedge clk); #1;
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Table: one-byte packets per source, strict rotation expected
    for (int v = 0; v < 6; v++) begin
      do_reset();
      for (int i = 0; i < N; i++) cnt[i] = 0;
      for (int p = 0; p < vecs[v].pkts; p++)
        for (int i = 0; i < N; i++)
          if (vecs[v].mask[i]) push_byte(i, 8'(8'h10 + 16*p + i), 1'b1);
      for (int j = 0; j < vecs[v].n_exp; j++) begin
        id = vecs[v].exp_ids[4*j +: 4];
        d  = 8'(8'h10 + 16*cnt[id] + int'(id));
        cnt[id]++;
        exp_q.push_back(entry(int'(id), d));
      end
      wait_idle(2000);
      check("vec_exp_drained", 32'(exp_q.size()), 32'd0);
      check("vec_grant_released", 32'(grant_active), 32'd0);
    end

    // Packet lock: src1 3C,12,7E holds the transmitter against src2
    do_reset();
    push_byte(1, 8'h3C, 1'b0); push_byte(1, 8'h12, 1'b0); push_byte(1, 8'h7E, 1'b1);
    push_byte(2, 8'h55, 1'b1);
    exp_q.push_back(entry(1, 8'h3C)); exp_q.push_back(entry(1, 8'h12));
    exp_q.push_back(entry(1, 8'h7E)); exp_q.push_back(entry(2, 8'h55));
    wait_idle(2000);
    check("lock_exp_drained", 32'(exp_q.size()), 32'd0);

    // Idle timeout: src3 stalls mid-packet, src0 waits
    do_reset();
    push_byte(3, 8'h01, 1'b0);
    exp_q.push_back(entry(3, 8'h01)); exp_q.push_back(entry(0, 8'hA0));
    wait_state(2'd3, 100, "to_wait_done");
    push_byte(0, 8'hA0, 1'b1);
    wait_state(2'd1, 100, "to_back_to_send");
    n = 0;
    do begin @(posedge clk); #1; n++; end while (grant_active && n < 200);
    check("idle_release_cycles", 32'(n), 32'd64);
    @(posedge clk); #1;
    check("regrant_active", 32'(grant_active), 32'd1);
    check("regrant_id", 32'(grant_id), 32'd0);
    wait_idle(2000);
    check("to_exp_drained", 32'(exp_q.size()), 32'd0);

    // Owner stalls twice below the timeout; grant must survive both
    do_reset();
    push_byte(3, 8'h01, 1'b0);
    exp_q.push_back(entry(3, 8'h01)); exp_q.push_back(entry(3, 8'h02));
    exp_q.push_back(entry(3, 8'h03)); exp_q.push_back(entry(1, 8'hB1));
    wait_state(2'd3, 100, "stall1_wait_done");
    wait_state(2'd1, 100, "stall1_send");
    push_byte(1, 8'hB1, 1'b1);
    wait_cycles(40);
    check("stall1_kept", 32'({grant_active, grant_id}), 32'h7);
    push_byte(3, 8'h02, 1'b0);
    wait_state(2'd3, 100, "stall2_wait_done");
    wait_state(2'd1, 100, "stall2_send");
    wait_cycles(40);
    check("stall2_kept", 32'({grant_active, grant_id}), 32'h7);
    push_byte(3, 8'h03, 1'b1);
    wait_idle(2000);
    check("stall_exp_drained", 32'(exp_q.size()), 32'd0);

    // Ack timeout: transmitter never raises busy
    do_reset();
    tie_busy_low = 1'b1;
    push_byte(0, 8'h77, 1'b1);
    exp_q.push_back(entry(0, 8'h77));
    wait_start(100);
    n = 0;
    do begin
      @(posedge clk); #1; n++;
      if (n == 1) check("start_one_cycle", 32'(tx_start), 32'd0);
    end while (!err_ack && n < 100);
    check("ack_timeout_cycles", 32'(n), 32'd15);
    check("ack_to_idle", 32'(dbg_state), 32'd0);
    check("ack_released", 32'(grant_active), 32'd0);
    tie_busy_low = 1'b0;
    push_byte(2, 8'h88, 1'b1);
    exp_q.push_back(entry(2, 8'h88));
    wait_idle(2000);
    check("err_ack_sticky", 32'(err_ack), 32'd1);

    // Reset mid-packet: outputs clear at once, no stale restart
    push_byte(1, 8'h3C, 1'b0); push_byte(1, 8'h12, 1'b0); push_byte(1, 8'h7E, 1'b1);
    exp_q.push_back(entry(1, 8'h3C)); exp_q.push_back(entry(1, 8'h12));
    wait_start(200);
    wait_start(200);
    wait_cycles(3);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("midrst");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      if (tx_start || grant_active) n++;
    end
    check("no_restart_after_reset", 32'(n), 32'd0);
    check("midrst_exp_drained", 32'(exp_q.size()), 32'd0);
    push_byte(2, 8'hC2, 1'b1); push_byte(0, 8'hC0, 1'b1);
    exp_q.push_back(entry(0, 8'hC0)); exp_q.push_back(entry(2, 8'hC2));
    wait_idle(2000);
    check("post_reset_exp_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
